// File: rtl/led_breather_pkg.sv
// Shared types and default parameters for the LED breathing-envelope block.
package led_breather_pkg;

    localparam int STATE_W = 3;

    localparam int         DEF_WIDTH      = 8;
    localparam int         DEF_STEP       = 1;
    localparam int         DEF_HOLD_TICKS = 64;
    localparam logic [7:0] DEF_LED_MASK   = 8'hFF;

    typedef enum logic [STATE_W-1:0] {
        ST_RISE    = 3'd0,
        ST_HOLD_HI = 3'd1,
        ST_FALL    = 3'd2,
        ST_HOLD_LO = 3'd3
    } env_state_e;

endpackage

// File: rtl/led_breather_pwm_compare.sv
// PWM comparator with registered LED drive. Optional squared-brightness duty
// stage is selected by the LED_BREATHER_GAMMA_EN macro.
module pwm_compare
    import led_breather_pkg::*;
#(
    parameter int         WIDTH    = DEF_WIDTH,
    parameter logic [7:0] LED_MASK = DEF_LED_MASK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] phase_i,
    input  logic [WIDTH-1:0] bright_i,
    output logic [7:0]       led_o
);

    logic [WIDTH-1:0] duty;
    logic             pwm_d;
    logic [7:0]       led_d;
    logic [7:0]       led_q;

`ifdef LED_BREATHER_GAMMA_EN
    logic [2*WIDTH-1:0] square;
    logic [WIDTH-1:0]   gamma_d;
    logic [WIDTH-1:0]   gamma_q;

    // Duty is the upper half of BRIGHT squared, registered to keep the
    // multiplier off the compare path.
    always_comb begin
        square  = {{WIDTH{1'b0}}, bright_i} * {{WIDTH{1'b0}}, bright_i};
        gamma_d = WIDTH'(square >> WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gamma_q <= '0;
        end else begin
            gamma_q <= gamma_d;
        end
    end

    assign duty = gamma_q;
`else
    assign duty = bright_i;
`endif

    assign pwm_d = (phase_i < duty);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_led
            assign led_d[gi] = pwm_d & LED_MASK[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_breather.sv
// Breathing-brightness envelope FSM driving a PWM on the J3 LEDs.
// Build option: LED_BREATHER_GAMMA_EN enables the squared-duty stage.
module led_breather
    import led_breather_pkg::*;
#(
    parameter int         WIDTH      = DEF_WIDTH,
    parameter int         STEP       = DEF_STEP,
    parameter int         HOLD_TICKS = DEF_HOLD_TICKS,
    parameter logic [7:0] LED_MASK   = DEF_LED_MASK
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic [WIDTH-1:0]   PHASE,
    input  logic               TICK,
    output logic [7:0]         O,
    output logic [STATE_W-1:0] STATE,
    output logic [WIDTH-1:0]   BRIGHT
);

    localparam int               HC_W      = $clog2(HOLD_TICKS + 1);
    localparam logic [WIDTH:0]   MAX_EXT   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH + 1)'(STEP);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_TICKS);
    localparam logic [HC_W-1:0]  HOLD_ONE  = HC_W'(1);

    env_state_e       state_q, state_d;
    logic [WIDTH-1:0] bright_q, bright_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [WIDTH:0]   sum;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_RISE;
            bright_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        hold_d   = hold_q;
        sum      = {1'b0, bright_q} + STEP_EXT;
        if (TICK) begin
            case (state_q)
                ST_RISE: begin
                    if (sum >= MAX_EXT) begin
                        bright_d = '1;
                        state_d  = ST_HOLD_HI;
                        hold_d   = HOLD_LOAD;
                    end else begin
                        bright_d = sum[WIDTH-1:0];
                    end
                end
                ST_HOLD_HI: begin
                    // A stray zero count still leaves the hold rather than wrapping.
                    if (hold_q <= HOLD_ONE) begin
                        state_d = ST_FALL;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q - HOLD_ONE;
                    end
                end
                ST_FALL: begin
                    if ({1'b0, bright_q} <= STEP_EXT) begin
                        bright_d = '0;
                        state_d  = ST_HOLD_LO;
                        hold_d   = HOLD_LOAD;
                    end else begin
                        bright_d = bright_q - STEP_EXT[WIDTH-1:0];
                    end
                end
                ST_HOLD_LO: begin
                    if (hold_q <= HOLD_ONE) begin
                        state_d = ST_RISE;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q - HOLD_ONE;
                    end
                end
                default: begin
                    state_d = ST_RISE;
                end
            endcase
        end
    end

    always_comb begin
        STATE  = state_q;
        BRIGHT = bright_q;
    end

    pwm_compare #(
        .WIDTH    (WIDTH),
        .LED_MASK (LED_MASK)
    ) u_pwm (
        .clk      (CLK),
        .rst_n    (RESETN),
        .phase_i  (PHASE),
        .bright_i (bright_q),
        .led_o    (O)
    );

endmodule

// File: doc/led_breather.md
# led_breather

Downstream consumer of the free-running 30-bit down-counter on the icestick LED path. It takes the counter's low byte as a PWM phase and its carry-out as a slow tick, and produces a "breathing" brightness envelope on the 8 J3 LEDs. Brightness ramps up, holds, ramps down and holds low under a small state machine. It replaces the raw `counter[29:22]` → `J3` hookup in `main`.

## Interface
Parameters:
- `WIDTH`, default 8: PWM phase and brightness resolution in bits.
- `STEP`, default 1: brightness increment or decrement per tick in RISE/FALL; valid range 1..2^WIDTH-1.
- `HOLD_TICKS`, default 64: ticks spent in each of HOLD_HI and HOLD_LO; must be ≥1.
- `LED_MASK`, default 8'hFF: LEDs driven by the PWM signal; unmasked LEDs are held at 0.

Ports:
- `CLK`, in, 1: single clock, the same clock as the counter.
- `RESETN`, in, 1: asynchronous, active-low reset.
- `PHASE`, in, WIDTH: PWM phase, taken from counter `O[WIDTH-1:0]`.
- `TICK`, in, 1: envelope advance strobe, taken from counter `COUT`; level-sampled.
- `O`, out, 8: LED drive, connects to `J3`.
- `STATE`, out, 3: current envelope state, for debug and the bench.
- `BRIGHT`, out, WIDTH: current linear brightness.

## Operation
- States: RISE, HOLD_HI, FALL, HOLD_LO. All state and envelope registers advance only on cycles where `TICK`=1.
- RISE: `BRIGHT` ← min(`BRIGHT`+`STEP`, 2^WIDTH-1). The addition is WIDTH+1 bits wide and saturates. On the tick that produces the max value, go to HOLD_HI and load `hold_cnt` ← `HOLD_TICKS`.
- HOLD_HI: each tick decrements `hold_cnt`. The tick that sees `hold_cnt`=1 moves to FALL. HOLD_HI therefore consumes exactly `HOLD_TICKS` ticks.
- FALL: `BRIGHT` ← max(`BRIGHT`-`STEP`, 0), saturating. On the tick that produces 0, go to HOLD_LO and load `hold_cnt` ← `HOLD_TICKS`.
- HOLD_LO: same counting rule as HOLD_HI, then go to RISE.
- `hold_cnt` is $clog2(HOLD_TICKS+1) bits wide.
- PWM: `duty` = `BRIGHT`, or the gamma-corrected value when that feature is enabled. `pwm` = (`PHASE` < `duty`), unsigned compare.
  - `duty`=0 means never on.
  - `duty`=2^WIDTH-1 means on for all phases except the maximum.
- `O[i]` = `pwm` & `LED_MASK[i]`.
- `TICK` held high for N cycles advances the envelope N steps. There is no edge detection.
- `STATE` encoding: RISE=0, HOLD_HI=1, FALL=2, HOLD_LO=3. Values 4–7 are illegal and recover to RISE with `BRIGHT` unchanged.

## Timing
- Reset values (asynchronous assert, synchronous release on the next `CLK` edge):
  - `STATE`=RISE
  - `BRIGHT`=0
  - `hold_cnt`=0
  - `O`=0
  - gamma pipeline register = 0
- Envelope: a `TICK` sampled at edge k updates `STATE` and `BRIGHT` as seen after edge k.
- `O` is registered. `PHASE` sampled at edge k appears on `O` after edge k, giving 1-cycle latency with linear duty.
- When `BRIGHT` changes, the new duty applies to the `PHASE` compare on the following edge.
- Reset mid-ramp or mid-hold: on assertion, all outputs are forced immediately to their reset values. There is no resume.

## Configuration
- `LED_BREATHER_GAMMA_EN` defined: `duty` = (`BRIGHT`*`BRIGHT`) >> WIDTH. The product is 2·WIDTH bits and is computed in a register stage. Duty therefore lags `BRIGHT` by 1 extra cycle; `PHASE`→`O` latency stays 1 cycle.
- `LED_BREATHER_GAMMA_EN` undefined: `duty` = `BRIGHT` combinationally. No multiplier is built.

## Structure
- Package `led_breather_pkg`:
  - state enum typedef with the encoding above
  - `STATE_W`=3
  - default parameter constants
- Sub-module `pwm_compare`: `PHASE` / `duty` / `LED_MASK` → registered `O`. The optional gamma stage lives here.
- The top level holds the envelope FSM, `BRIGHT`, and `hold_cnt`.

## Test plan
All scenarios use `WIDTH`=8 unless noted.
- **Reset state:** assert `RESETN`=0 mid-clock → `O`=0, `STATE`=0 and `BRIGHT`=0 immediately, without waiting for an edge.
- **Full envelope:** `STEP`=64, `HOLD_TICKS`=2, `TICK` pulsed every 4 cycles → `BRIGHT` sequence 64, 128, 192, 255, then 2 ticks in HOLD_HI, then 191, 127, 63, 0, then 2 ticks in HOLD_LO, then back to RISE.
- **PWM duty:** force `BRIGHT`=100 (`STEP`=100, 1 tick), `TICK`=0, sweep `PHASE` 0..255 → exactly 100 cycles of `O`=8'hFF, 1-cycle latency.
- **Extremes:** `BRIGHT`=0 → `O` never set. `BRIGHT`=255 → `O`=0 only for `PHASE`=255.
- **Masking and level tick:** `LED_MASK`=8'h0F, `TICK` held high 3 cycles, `STEP`=1 → `BRIGHT`=3 and `O[7:4]` always 0.
- **Gamma:** with `LED_BREATHER_GAMMA_EN` defined and `BRIGHT`=128 → duty 64, so `O` is high for 64 of 256 phases, and the duty update lands 1 cycle after the `BRIGHT` change.
